// File: rtl/wb_port_if.sv
// Writeback port bundle: ALU and load-unit requests, decode-stage scoreboard
// lookup, and the registered register-file write port.
interface wb_port_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);

  logic            alu_valid;
  logic            alu_ready;
  logic [RW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            mem_valid;
  logic            mem_ready;
  logic [RW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_wd;
  logic            iss_valid;
  logic [RW-1:0]   iss_rd;
  logic [RW-1:0]   iss_rs1;
  logic [RW-1:0]   iss_rs2;
  logic            iss_stall;
  logic [NREG-1:0] busy;
  logic            wen;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] wd;

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output mem_valid, mem_rd, mem_wd,
    output iss_valid, iss_rd, iss_rs1, iss_rs2,
    input  alu_ready, mem_ready, iss_stall, busy, wen, rd, wd
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  mem_valid, mem_rd, mem_wd,
    input  iss_valid, iss_rd, iss_rs1, iss_rs2,
    output alu_ready, mem_ready, iss_stall, busy, wen, rd, wd
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by ALU and load unit, with a
// pending-write scoreboard for RAW stall detection in decode.
module wb_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int NREG       = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic     clk,
  input  logic     rst,
  wb_port_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic            last_grant_mem_reg;
  logic            wen_reg;
  logic [RW-1:0]   rd_reg;
  logic [XLEN-1:0] wd_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  logic            alu_wins;
  logic            mem_wins;
  logic            xfer;
  logic [RW-1:0]   grant_rd;
  logic [XLEN-1:0] grant_wd;

  // On a tie the ALU wins only if the MEM side was served last (or ALU has fixed priority).
  assign alu_wins = bus.alu_valid &&
                    (!bus.mem_valid || (FIXED_PRIO != 0) || last_grant_mem_reg);
  assign mem_wins = bus.mem_valid && !alu_wins;
  assign xfer     = alu_wins || mem_wins;
  assign grant_rd = alu_wins ? bus.alu_rd : bus.mem_rd;
  assign grant_wd = alu_wins ? bus.alu_wd : bus.mem_wd;

  assign bus.alu_ready = alu_wins;
  assign bus.mem_ready = mem_wins;
  assign bus.iss_stall = busy_reg[bus.iss_rs1] | busy_reg[bus.iss_rs2];
  assign bus.busy      = busy_reg;
  assign bus.wen       = wen_reg;
  assign bus.rd        = rd_reg;
  assign bus.wd        = wd_reg;

  assign busy_next[0] = 1'b0;

  // A new issue to the same register wins over a retiring older write.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
      localparam logic [RW-1:0] IDX = RW'(gi);
      assign busy_next[gi] = (bus.iss_valid && bus.iss_rd == IDX) ? 1'b1 :
                             (xfer && grant_rd == IDX)            ? 1'b0 :
                                                                    busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_mem_reg <= 1'b1;
      wen_reg            <= 1'b0;
      rd_reg             <= '0;
      wd_reg             <= '0;
      busy_reg           <= '0;
    end else begin
      wen_reg  <= xfer && (grant_rd != '0);
      busy_reg <= busy_next;
      if (xfer) begin
        last_grant_mem_reg <= mem_wins;
        rd_reg             <= grant_rd;
        wd_reg             <= grant_wd;
      end
    end
  end
endmodule
